// File: rtl/wr_port_rr_arbiter.sv
// wr_port_rr_arbiter: burst-based round-robin arbiter for the shared register-file write port
module wr_port_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  input  logic [3:0] last,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic [3:0] gnt,
  output logic       xfer,
  output logic       busy
);
  localparam int CW = $clog2(MAX_HOLD + 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [1:0] ptr, start, pick;
  logic [3:0] cand;
  logic [CW-1:0] cnt;
  logic found, done;
  generate
    if (MAX_HOLD < 1) begin : g_bad_hold
      $error("wr_port_rr_arbiter: MAX_HOLD must be >= 1");
    end
  endgenerate
  // while granted, the next pick starts after g and skips it, so a release always rotates
  always_comb begin
    start = (state == GRANT) ? gnt_idx + 2'd1 : ptr;
    cand  = (state == GRANT) ? req & ~gnt : req;
    found = 1'b0;
    pick  = start;
    for (int k = 3; k >= 0; k--)
      if (cand[start + 2'(k)]) begin
        found = 1'b1;
        pick  = start + 2'(k);
      end
  end
  assign done      = !req[gnt_idx] | last[gnt_idx] | (cnt == CW'(MAX_HOLD - 1));
  assign gnt       = gnt_valid ? 4'd1 << gnt_idx : 4'd0;
  assign xfer      = gnt_valid & req[gnt_idx];
  assign busy      = state == GRANT;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      gnt_idx   <= 2'd0;
      gnt_valid <= 1'b0;
      ptr       <= 2'd0;
      cnt       <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        state     <= GRANT;
        gnt_idx   <= pick;
        gnt_valid <= 1'b1;
        cnt       <= '0;
      end
    end else if (done) begin
      ptr <= gnt_idx + 2'd1;
      cnt <= '0;
      if (found) gnt_idx <= pick;
      else begin
        state     <= IDLE;
        gnt_valid <= 1'b0;
      end
    end else
      cnt <= cnt + 1'b1;
endmodule

// File: tb/tb_wr_port_rr_arbiter.sv
// tb_wr_port_rr_arbiter: directed checks of the write-port arbiter plus random invariant run
module tb_wr_port_rr_arbiter;
  localparam int MH = 4;
  logic clk = 1'b0;
  logic reset_n;
  logic [3:0] req, last, gnt;
  logic [1:0] gnt_idx;
  logic gnt_valid, xfer, busy;
  int total = 0, bad = 0;
  int wt[4];
  int mx = 0;
  logic [3:0] e;
  wr_port_rr_arbiter #(.MAX_HOLD(MH)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .last(last),
    .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .gnt(gnt), .xfer(xfer), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic exp_out(input string t, input logic [3:0] g, input logic x, input logic b);
    chk({t, ".gnt"}, gnt, g);
    chk({t, ".valid"}, gnt_valid, |g);
    chk({t, ".xfer"}, xfer, x);
    chk({t, ".busy"}, busy, b);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset_n = 1'b1; req = 4'h0; last = 4'h0;
    #1 reset_n = 1'b0; req = 4'hf;
    #2 exp_out("rst_async", 4'b0000, 1'b0, 1'b0);
    step(); step();
    exp_out("rst_held", 4'b0000, 1'b0, 1'b0);
    chk("rst_idx", gnt_idx, 8'd0);
    #2 reset_n = 1'b1;
    step();
    exp_out("t1_first", 4'b0001, 1'b1, 1'b1);
    chk("t1_idx", gnt_idx, 8'd0);
    req = 4'h0;
    step();
    exp_out("t1_drop", 4'b0000, 1'b0, 1'b0);
    req = 4'b0100;
    step();
    exp_out("t2_b1", 4'b0100, 1'b1, 1'b1);
    chk("t2_idx", gnt_idx, 8'd2);
    step();
    exp_out("t2_b2", 4'b0100, 1'b1, 1'b1);
    last = 4'b0100;
    step();
    exp_out("t2_end", 4'b0000, 1'b0, 1'b0);
    req = 4'b1001; last = 4'h0;
    step();
    exp_out("t2_ptr3", 4'b1000, 1'b1, 1'b1);
    req = 4'h0;
    step();
    exp_out("t2_idle", 4'b0000, 1'b0, 1'b0);
    // ptr wrapped to 0; full-load rotation with non-granted lasts asserted, then last at the hold limit
    req = 4'hf;
    for (int i = 0; i < 24; i++) begin
      step();
      e = 4'b0001 << ((i / 4) % 4);
      exp_out($sformatf("t3_c%0d", i), e, 1'b1, 1'b1);
      last = (i == 19) ? 4'hf : ~e;
    end
    last = 4'h0; req = 4'h0; reset_n = 1'b0;
    #2 reset_n = 1'b1;
    req = 4'b0010;
    step();
    exp_out("t4_b1", 4'b0010, 1'b1, 1'b1);
    req = 4'b1010;
    step();
    exp_out("t4_b2", 4'b0010, 1'b1, 1'b1);
    req = 4'b1000;
    #1 exp_out("t4_drop", 4'b0010, 1'b0, 1'b1);
    step();
    exp_out("t4_next", 4'b1000, 1'b1, 1'b1);
    req = 4'b1010;
    step();
    exp_out("t4_hold", 4'b1000, 1'b1, 1'b1);
    #2 reset_n = 1'b0;
    #1 exp_out("t5_async", 4'b0000, 1'b0, 1'b0);
    chk("t5_idx", gnt_idx, 8'd0);
    req = 4'b0010;
    step();
    #2 reset_n = 1'b1;
    step();
    exp_out("t5_regrant", 4'b0010, 1'b1, 1'b1);
    chk("t5_idx2", gnt_idx, 8'd1);
    reset_n = 1'b0; req = 4'h0;
    #1 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) wt[i] = 0;
    for (int n = 0; n < 2000; n++) begin
      step();
      chk("r_onehot", 8'($onehot0(gnt)), 8'd1);
      chk("r_decode", gnt, gnt_valid ? 4'd1 << gnt_idx : 4'd0);
      chk("r_xfer", xfer, gnt_valid & req[gnt_idx]);
      for (int i = 0; i < 4; i++) begin
        wt[i] = (req[i] && !gnt[i]) ? wt[i] + 1 : 0;
        if (wt[i] > mx) mx = wt[i];
      end
      for (int i = 0; i < 4; i++)
        if ($urandom_range(7) == 0) req[i] = ~req[i];
      last = 4'($urandom) & 4'($urandom);
    end
    chk("r_starve", 8'(mx <= 3 * MH + 3), 8'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
